// File: rtl/alu_seq_exec.sv
// Sequential RISC-V execute unit: one-cycle logic/arith/compare, iterative 1-bit/cycle shifts.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_seq_exec #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      control_in,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal,
   output logic            busy
);

   localparam int unsigned SHAMT_W = $clog2(XLEN);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_XOR  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [XLEN-1:0]     res_q, res_d;
   logic                zero_q, zero_d;
   logic                illegal_q, illegal_d;
   logic                out_valid_q, out_valid_d;
   logic                busy_q, busy_d;
   logic [XLEN-1:0]     work_q, work_d;
   logic [SHAMT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]          shop_q, shop_d;

   logic [SHAMT_W-1:0]  shamt_c;
   logic                is_shift_c;
   logic                accept_c;
   logic [XLEN-1:0]     alu_res_c;
   logic                alu_ill_c;
   logic [XLEN-1:0]     work_shift_c;

   assign shamt_c    = op_b[SHAMT_W-1:0];
   assign is_shift_c = (control_in == OP_SLL) || (control_in == OP_SRL) || (control_in == OP_SRA);
   assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
   assign accept_c   = in_valid && in_ready;

   // Single-cycle result for every op; iterative shifts only use it when shamt is zero.
   always_comb begin
      alu_res_c = '0;
      alu_ill_c = 1'b0;
      case (control_in)
         OP_ADD:  alu_res_c = op_a + op_b;
         OP_SUB:  alu_res_c = op_a - op_b;
         OP_XOR:  alu_res_c = op_a ^ op_b;
         OP_OR:   alu_res_c = op_a | op_b;
         OP_AND:  alu_res_c = op_a & op_b;
`ifdef ALU_FAST_SHIFT_EN
         OP_SLL:  alu_res_c = op_a << shamt_c;
         OP_SRL:  alu_res_c = op_a >> shamt_c;
         OP_SRA:  alu_res_c = XLEN'($signed(op_a) >>> shamt_c);
`else
         OP_SLL:  alu_res_c = op_a;
         OP_SRL:  alu_res_c = op_a;
         OP_SRA:  alu_res_c = op_a;
`endif
         OP_SLT:  alu_res_c = XLEN'($signed(op_a) < $signed(op_b));
         OP_SLTU: alu_res_c = XLEN'(op_a < op_b);
         default: alu_ill_c = 1'b1;
      endcase
   end

   // One-bit step of the working register; shop holds control_in[1:0] of the shift.
   always_comb begin
      case (shop_q)
         2'b01:   work_shift_c = work_q << 1;
         2'b10:   work_shift_c = work_q >> 1;
         default: work_shift_c = {work_q[XLEN-1], work_q[XLEN-1:1]};
      endcase
   end

   always_comb begin
      state_d   = state_q;
      res_d     = res_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
      work_d    = work_q;
      cnt_d     = cnt_q;
      shop_d    = shop_q;
      case (state_q)
         ST_IDLE, ST_HOLD: begin
            if (accept_c) begin
`ifdef ALU_FAST_SHIFT_EN
               if (1'b0) begin
`else
               if (is_shift_c && (shamt_c != '0)) begin
`endif
                  state_d = ST_SHIFT;
                  work_d  = op_a;
                  cnt_d   = shamt_c;
                  shop_d  = control_in[1:0];
               end else begin
                  state_d   = ST_HOLD;
                  res_d     = alu_res_c;
                  zero_d    = (alu_res_c == '0);
                  illegal_d = alu_ill_c;
               end
            end else if (state_q == ST_HOLD && out_ready) begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            work_d = work_shift_c;
            cnt_d  = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
               state_d   = ST_HOLD;
               res_d     = work_shift_c;
               zero_d    = (work_shift_c == '0);
               illegal_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      out_valid_d = (state_d == ST_HOLD);
`ifdef ALU_FAST_SHIFT_EN
      busy_d = 1'b0;
`else
      busy_d = (state_d == ST_SHIFT);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         res_q       <= '0;
         zero_q      <= 1'b0;
         illegal_q   <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         work_q      <= '0;
         cnt_q       <= '0;
         shop_q      <= '0;
      end else begin
         state_q     <= state_d;
         res_q       <= res_d;
         zero_q      <= zero_d;
         illegal_q   <= illegal_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         work_q      <= work_d;
         cnt_q       <= cnt_d;
         shop_q      <= shop_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = res_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed cases plus random ops against a behavioural model.
module tb_alu_seq_exec;

   localparam int unsigned XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [3:0]      control_in = '0;
   logic [XLEN-1:0] op_a = '0;
   logic [XLEN-1:0] op_b = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            illegal;
   logic            busy;

   int n_cmp = 0;
   int n_err = 0;

   alu_seq_exec #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .control_in(control_in), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: result, illegal flag and end-to-end latency in clock edges.
   function automatic void ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
      int sh;
      sh  = int'(b[4:0]);
      r   = '0;
      ill = 1'b0;
      lat = 1;
      case (c)
         4'd0: r = a + b;
         4'd1: r = a - b;
         4'd2: r = a ^ b;
         4'd3: r = a | b;
         4'd4: r = a & b;
         4'd5: begin r = a << sh; lat = 1 + sh; end
         4'd6: begin r = a >> sh; lat = 1 + sh; end
         4'd7: begin r = $signed(a) >>> sh; lat = 1 + sh; end
         4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd9: r = (a < b) ? 32'd1 : 32'd0;
         default: ill = 1'b1;
      endcase
`ifdef ALU_FAST_SHIFT_EN
      lat = 1;
`endif
   endfunction

   task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit drain);
      logic [31:0] r;
      logic        ill;
      int          elat, lat, busy_n;
      ref_op(c, a, b, r, ill, elat);
      @(negedge clk);
      check("ready_idle", 32'(in_ready), 32'd1);
      in_valid = 1'b1; control_in = c; op_a = a; op_b = b; out_ready = 1'b0;
      @(posedge clk); #1;
      // junk on the inputs while in_ready is low must be ignored
      in_valid = 1'($urandom_range(0, 1)); control_in = 4'($urandom);
      op_a = $urandom; op_b = $urandom;
      lat = 1; busy_n = 0;
      @(negedge clk);
      while (!out_valid && lat < 40) begin
         busy_n += int'(busy);
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), 32'(elat));
      check("busy_cycles", 32'(busy_n), 32'(elat - 1));
      check("result", result, r);
      check("zero", 32'(zero), 32'(r == 32'd0));
      check("illegal", 32'(illegal), 32'(ill));
      check("ready_hold", 32'(in_ready), 32'd0);
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_result", result, r);
      end
      if (drain) begin
         in_valid = 1'b0; out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         check("drained", 32'(out_valid), 32'd0);
      end
   endtask

   initial begin
      logic [3:0]  c;
      logic [31:0] a, b;
      bit          seen;
      #12;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_zero", 32'(zero), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(4'd0, 32'd5, 32'd7, 0, 1);
      run_op(4'd1, 32'd7, 32'd7, 0, 1);
      run_op(4'd1, 32'd3, 32'd5, 0, 1);
      run_op(4'd8, 32'hFFFF_FFFF, 32'd1, 0, 1);
      run_op(4'd9, 32'hFFFF_FFFF, 32'd1, 0, 1);
      run_op(4'd7, 32'h8000_0000, 32'd4, 0, 1);
      run_op(4'd6, 32'h8000_0000, 32'd4, 0, 1);
      run_op(4'd5, 32'h0000_0001, 32'd31, 0, 1);
      run_op(4'd6, 32'h1234_5678, 32'd0, 0, 1);
      run_op(4'd15, 32'h1234_5678, 32'h9, 0, 1);
      run_op(4'd0, 32'd1, 32'd1, 0, 1);

      // Backpressure, then drain and accept in the same cycle.
      run_op(4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 10, 0);
      in_valid = 1'b1; control_in = 4'd4; op_a = 32'hF0F0_F0F0; op_b = 32'h3C3C_3C3C;
      out_ready = 1'b1;
      #1;
      check("b2b_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      check("b2b_valid", 32'(out_valid), 32'd1);
      check("b2b_result", result, 32'h3030_3030);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("b2b_drained", 32'(out_valid), 32'd0);

      // Reset during an in-flight shift.
      in_valid = 1'b1; control_in = 4'd5; op_a = 32'h0000_0001; op_b = 32'd20;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mrst_valid", 32'(out_valid), 32'd0);
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_result", result, 32'd0);
      check("mrst_zero", 32'(zero), 32'd0);
      check("mrst_illegal", 32'(illegal), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("mrst_ready", 32'(in_ready), 32'd1);
      seen = 1'b0;
      repeat (25) begin
         @(negedge clk);
         seen |= out_valid;
      end
      check("no_stale_valid", 32'(seen), 32'd0);

      // Random ops against the reference model.
      for (int i = 0; i < 40; i++) begin
         c = 4'($urandom_range(0, 15));
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? a : $urandom;
         run_op(c, a, b, $urandom_range(0, 3), 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
